// File: rtl/rpn_stack_ctrl.sv
// Operand stack and ADD/SUB sequencer for the RPN ALU.
// Pops two operands onto the external ripple adder, waits one settle cycle, then pushes the result back.
module rpn_stack_ctrl #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [DW-1:0]                push_data,
   input  logic                         op_valid,
   input  logic [1:0]                   op_sel,
   output logic [DW-1:0]                alu_a,
   output logic [DW-1:0]                alu_b,
   output logic                         alu_cin,
   input  logic [DW-1:0]                alu_s,
   input  logic                         alu_co,
   output logic                         busy,
   output logic [DW-1:0]                tos,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         carry_flag,
   output logic                         ovf_flag,
   output logic                         err
);

   localparam int DPW = $clog2(DEPTH+1);
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_DROP = 2'b10;
   localparam logic [1:0] OP_SWAP = 2'b11;

   typedef enum logic [1:0] {IDLE, OPER, WRITE} state_t;

   state_t          state_q, state_d;
   logic [DPW-1:0]  depth_q, depth_d;
   logic [DW-1:0]   stk_q [DEPTH];
   logic [DW-1:0]   stk_d [DEPTH];
   logic [DW-1:0]   alu_a_q, alu_a_d;
   logic [DW-1:0]   alu_b_q, alu_b_d;
   logic            alu_cin_q, alu_cin_d;
   logic [DW-1:0]   res_q, res_d;
   logic            rco_q, rco_d;
   logic            carry_q, carry_d;
   logic            ovf_q, ovf_d;
   logic            err_q, err_d;
   logic [DW-1:0]   ent_a, ent_b;

   // ent_b is the top entry, ent_a the one beneath; both read 0 when absent
   always_comb begin
      ent_a = '0;
      ent_b = '0;
      for (int i = 0; i < DEPTH; i++)
         if (depth_q == DPW'(i+1)) ent_b = stk_q[i];
      for (int i = 0; i < DEPTH-1; i++)
         if (depth_q == DPW'(i+2)) ent_a = stk_q[i];
   end

   always_comb begin
      state_d   = state_q;
      depth_d   = depth_q;
      stk_d     = stk_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_cin_d = alu_cin_q;
      res_d     = res_q;
      rco_d     = rco_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               case (op_sel)
                  OP_ADD, OP_SUB: begin
                     if (depth_q < DPW'(2)) begin
                        err_d = 1'b1;
                     end else begin
                        alu_a_d   = ent_a;
                        alu_b_d   = (op_sel == OP_SUB) ? ~ent_b : ent_b;
                        alu_cin_d = (op_sel == OP_SUB);
                        state_d   = OPER;
                     end
                  end
                  OP_DROP: begin
                     if (depth_q == '0) err_d = 1'b1;
                     else               depth_d = depth_q - DPW'(1);
                  end
                  OP_SWAP: begin
                     if (depth_q < DPW'(2)) begin
                        err_d = 1'b1;
                     end else begin
                        for (int i = 0; i < DEPTH-1; i++)
                           if (depth_q == DPW'(i+2)) begin
                              stk_d[i]   = ent_b;
                              stk_d[i+1] = ent_a;
                           end
                     end
                  end
                  default: ;
               endcase
            end else if (push) begin
               if (depth_q == DPW'(DEPTH)) begin
                  err_d = 1'b1;
               end else begin
                  for (int i = 0; i < DEPTH; i++)
                     if (depth_q == DPW'(i)) stk_d[i] = push_data;
                  depth_d = depth_q + DPW'(1);
               end
            end
         end
         OPER: begin
            res_d   = alu_s;
            rco_d   = alu_co;
            state_d = WRITE;
         end
         WRITE: begin
            for (int i = 0; i < DEPTH-1; i++)
               if (depth_q == DPW'(i+2)) stk_d[i] = res_q;
            depth_d = depth_q - DPW'(1);
            carry_d = rco_q;
            ovf_d   = (alu_a_q[DW-1] == alu_b_q[DW-1]) && (res_q[DW-1] != alu_a_q[DW-1]);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         depth_q   <= '0;
         for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_cin_q <= 1'b0;
         res_q     <= '0;
         rco_q     <= 1'b0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         depth_q   <= depth_d;
         stk_q     <= stk_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_cin_q <= alu_cin_d;
         res_q     <= res_d;
         rco_q     <= rco_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cin    = alu_cin_q;
   assign busy       = (state_q != IDLE);
   assign tos        = ent_b;
   assign depth      = depth_q;
   assign carry_flag = carry_q;
   assign ovf_flag   = ovf_q;
   assign err        = err_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: directed test-plan steps followed by random commands,
// checked against a queue-based stack model with plain integer arithmetic.
module tb_rpn_stack_ctrl;

   logic       clk = 1'b0;
   logic       rst, push, op_valid;
   logic [7:0] push_data;
   logic [1:0] op_sel;
   logic [7:0] alu_a, alu_b, alu_s, tos;
   logic       alu_cin, alu_co, busy, carry_flag, ovf_flag, err;
   logic [2:0] depth;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   logic       m_carry, m_ovf;

   rpn_stack_ctrl #(.DEPTH(4), .DW(8)) dut (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data),
      .op_valid(op_valid), .op_sel(op_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_s(alu_s), .alu_co(alu_co),
      .busy(busy), .tos(tos), .depth(depth),
      .carry_flag(carry_flag), .ovf_flag(ovf_flag), .err(err)
   );

   // external ripple adder
   assign {alu_co, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_depth"}, 32'(depth), 32'(q.size()));
      chk({tag, "_tos"}, 32'(tos), (q.size() == 0) ? 32'd0 : 32'(q[q.size()-1]));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_carry"}, 32'(carry_flag), 32'(m_carry));
      chk({tag, "_ovf"}, 32'(ovf_flag), 32'(m_ovf));
   endtask

   task automatic chk_err_pulse(input string tag);
      chk({tag, "_err"}, 32'(err), 32'd1);
      tick();
      chk({tag, "_err_clr"}, 32'(err), 32'd0);
   endtask

   function automatic int sval(input logic [7:0] v);
      return v[7] ? int'(v) - 256 : int'(v);
   endfunction

   task automatic cmd_push(input logic [7:0] v);
      push = 1'b1; push_data = v;
      tick();
      push = 1'b0;
      if (q.size() < 4) begin
         q.push_back(v);
         chk("push_err", 32'(err), 32'd0);
         chk_state("push");
      end else begin
         chk_state("push_full");
         chk_err_pulse("push_full");
      end
   endtask

   task automatic cmd_op(input logic [1:0] sel, input bit with_push, input bit noise);
      int n, a, b, r;
      logic [7:0] ta, tb8;
      n = q.size();
      op_valid = 1'b1; op_sel = sel; push = with_push; push_data = 8'hA5;
      tick();
      op_valid = 1'b0; push = 1'b0;
      if (sel <= 2'd1 && n >= 2) begin
         ta = q[n-2]; tb8 = q[n-1];
         chk("op_alu_a", 32'(alu_a), 32'(ta));
         chk("op_alu_b", 32'(alu_b), (sel == 2'd1) ? 32'(8'hFF - tb8) : 32'(tb8));
         chk("op_alu_cin", 32'(alu_cin), 32'(sel == 2'd1));
         chk("op_busy0", 32'(busy), 32'd1);
         chk("op_err", 32'(err), 32'd0);
         if (noise) begin
            push = 1'b1; push_data = 8'($urandom);
            op_valid = 1'b1; op_sel = 2'($urandom);
         end
         tick();
         chk("op_busy1", 32'(busy), 32'd1);
         tick();
         push = 1'b0; op_valid = 1'b0;
         a = int'(ta); b = int'(tb8);
         if (sel == 2'd0) begin
            r = a + b;
            m_carry = (r > 255);
            m_ovf = (sval(ta) + sval(tb8) > 127) || (sval(ta) + sval(tb8) < -128);
         end else begin
            r = a - b;
            m_carry = (a >= b);
            m_ovf = (sval(ta) - sval(tb8) > 127) || (sval(ta) - sval(tb8) < -128);
         end
         void'(q.pop_back());
         void'(q.pop_back());
         q.push_back(8'(r & 255));
         chk_state("op_done");
      end else if (sel <= 2'd1) begin
         chk_state("op_under");
         chk_err_pulse("op_under");
      end else if (sel == 2'd2) begin
         if (n >= 1) begin
            void'(q.pop_back());
            chk("drop_err", 32'(err), 32'd0);
            chk_state("drop");
         end else begin
            chk_state("drop_empty");
            chk_err_pulse("drop_empty");
         end
      end else begin
         if (n >= 2) begin
            ta = q[n-2]; q[n-2] = q[n-1]; q[n-1] = ta;
            chk("swap_err", 32'(err), 32'd0);
            chk_state("swap");
         end else begin
            chk_state("swap_short");
            chk_err_pulse("swap_short");
         end
      end
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; op_valid = 1'b0; push_data = '0; op_sel = '0;
      q.delete(); m_carry = 1'b0; m_ovf = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk_state("reset");
      chk("reset_alu_a", 32'(alu_a), 32'd0);
      chk("reset_alu_b", 32'(alu_b), 32'd0);
      chk("reset_cin", 32'(alu_cin), 32'd0);
      chk("reset_err", 32'(err), 32'd0);

      cmd_push(8'h25); cmd_push(8'h13); cmd_op(2'd0, 1'b0, 1'b0);
      chk("add_38", 32'(tos), 32'h38);
      cmd_push(8'hFF); cmd_push(8'h01); cmd_op(2'd0, 1'b0, 1'b0);
      chk("add_carry", 32'(carry_flag), 32'd1);
      cmd_push(8'h7F); cmd_push(8'h01); cmd_op(2'd0, 1'b0, 1'b0);
      chk("add_ovf", 32'(ovf_flag), 32'd1);
      cmd_op(2'd2, 1'b0, 1'b0); cmd_op(2'd2, 1'b0, 1'b0); cmd_op(2'd2, 1'b0, 1'b0);
      cmd_push(8'h05); cmd_push(8'h07); cmd_op(2'd1, 1'b0, 1'b0);
      chk("sub_fe", 32'(tos), 32'hFE);
      cmd_push(8'h07); cmd_push(8'h05); cmd_op(2'd1, 1'b0, 1'b0);
      chk("sub_02", 32'(tos), 32'h02);
      cmd_op(2'd2, 1'b0, 1'b0); cmd_op(2'd2, 1'b0, 1'b0);

      for (int i = 0; i < 5; i++) cmd_push(8'(8'h30 + i));
      for (int i = 0; i < 5; i++) cmd_op(2'd2, 1'b0, 1'b0);
      cmd_push(8'h01); cmd_op(2'd0, 1'b0, 1'b0); cmd_op(2'd3, 1'b0, 1'b0);
      cmd_op(2'd2, 1'b0, 1'b0);

      cmd_push(8'h11); cmd_push(8'h22); cmd_op(2'd3, 1'b0, 1'b0);
      chk("swap_11", 32'(tos), 32'h11);
      cmd_op(2'd1, 1'b0, 1'b1);
      chk("sub_11", 32'(tos), 32'h11);
      cmd_push(8'h40); cmd_op(2'd0, 1'b1, 1'b0);
      chk("op_wins", 32'(tos), 32'h51);

      // reset while the adder result is in flight
      cmd_push(8'h09);
      op_valid = 1'b1; op_sel = 2'd0;
      tick();
      op_valid = 1'b0;
      chk("rst_mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete(); m_carry = 1'b0; m_ovf = 1'b0;
      chk_state("rst_mid");
      chk("rst_mid_alu_a", 32'(alu_a), 32'd0);
      chk("rst_mid_err", 32'(err), 32'd0);
      tick(); tick();
      chk_state("rst_mid_stale");

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 5) cmd_push(8'($urandom));
         else cmd_op(2'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
- Operand stack and sequencer for the 8-bit RPN ALU. It sits directly upstream of the 8-bit ripple adder and feeds it.
- It accepts pushed operands and operation commands. For ADD/SUB it pops the two top entries and drives them, with carry-in, onto the adder inputs.
- It captures the adder's sum and carry-out and pushes the result back. It also handles stack bookkeeping operations (DROP, SWAP) and error reporting.

Parameters:
- DEPTH, 4, number of 8-bit stack entries; must be ≥2.
- DW, 8, data width; must match the adder width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  push request; push_data is sampled when accepted.
- push_data  input  DW  operand to push.
- op_valid  input  1  operation request; op_sel is sampled when accepted.
- op_sel  input  2  00 ADD, 01 SUB, 10 DROP, 11 SWAP.
- alu_a  output  DW  adder operand A (registered).
- alu_b  output  DW  adder operand B (registered; already inverted for SUB).
- alu_cin  output  1  adder carry-in (registered).
- alu_s  input  DW  adder sum.
- alu_co  input  1  adder carry-out.
- busy  output  1  high while an arithmetic operation is in flight; commands are ignored while high.
- tos  output  DW  current top of stack; 0 when the stack is empty.
- depth  output  $clog2(DEPTH+1)  number of valid entries.
- carry_flag  output  1  Co of the last ADD/SUB; for SUB, 1 means no borrow.
- ovf_flag  output  1  signed overflow of the last ADD/SUB.
- err  output  1  one-cycle pulse when a command is rejected (stack overflow or underflow).

Behaviour:
- Reset (synchronous, active-high) applies from any state, including mid-operation. It forces:
  - state IDLE, depth 0, all entries 0;
  - alu_a, alu_b, alu_cin, busy, carry_flag, ovf_flag and err to 0.
  - Any in-flight result is discarded.
- States: IDLE, OPER, WRITE. busy = (state != IDLE).
- Commands are accepted only in IDLE. Inputs asserted while busy are ignored and raise no err.
- If push and op_valid are both high in IDLE, op_valid wins and the push is dropped silently.
- PUSH:
  - depth < DEPTH: the entry is written and depth increments at the same edge; tos shows push_data in the next cycle.
  - depth == DEPTH: no change; err pulses for one cycle.
- DROP:
  - depth ≥ 1: depth decrements in one cycle.
  - depth == 0: err pulses.
- SWAP:
  - depth ≥ 2: the top two entries are exchanged in one cycle.
  - otherwise: err pulses and the stack is unchanged.
- ADD/SUB with depth < 2: err pulses, state stays IDLE, flags unchanged.
- ADD/SUB with depth ≥ 2, at acceptance edge N:
  - Let A = entry[depth-2] and B = entry[depth-1].
  - The edge registers alu_a = A.
  - ADD: alu_b = B, alu_cin = 0.
  - SUB: alu_b = ~B, alu_cin = 1.
  - State goes to OPER.
- OPER (one full cycle for the ripple chain to settle): at edge N+1, alu_s and alu_co are captured into an internal result register. State goes to WRITE.
- WRITE: at edge N+2:
  - the result is written to entry[depth-2] and depth decrements by 1;
  - carry_flag = captured Co;
  - ovf_flag = (alu_a[DW-1] == alu_b[DW-1]) && (result[DW-1] != alu_a[DW-1]);
  - state returns to IDLE.
- Net effect: busy is high for exactly 2 cycles, and the new tos is visible 2 cycles after acceptance. The next command can be accepted at edge N+3.
- alu_a, alu_b and alu_cin hold their values outside OPER and are not cleared.
- Arithmetic wraps modulo 2^DW; the result is never saturated.
- Entries above depth are don't-care, but tos must read 0 when depth == 0.

Test Plan:
- Reset, then push 0x25 and push 0x13, then ADD → alu_a=0x25, alu_b=0x13, alu_cin=0; busy high 2 cycles; then tos=0x38, depth=1, carry_flag=0, ovf_flag=0.
- Push 0xFF, push 0x01, ADD → tos=0x00, carry_flag=1, ovf_flag=0. Push 0x7F, push 0x01, ADD → tos=0x80, ovf_flag=1, carry_flag=0.
- Push 0x05, push 0x07, SUB → alu_b=0xF8, alu_cin=1; tos=0xFE, carry_flag=0 (borrow). Push 0x07, push 0x05, SUB → tos=0x02, carry_flag=1.
- Push 5 values with DEPTH=4 → fifth push gives a one-cycle err pulse and depth stays 4. DROP ×4 then DROP → err pulse, depth 0, tos 0. ADD with depth 1 → err, no busy.
- Push 0x11, 0x22; SWAP → tos=0x11; SUB → tos=0x11 (0x22−0x11); push and ADD asserted in the busy cycle are ignored (depth unchanged); push+op_valid together in IDLE → op executes, push dropped.
- Issue ADD, assert rst during OPER → next cycle: depth 0, busy 0, tos 0, flags 0, stale result never written.
